// File: rtl/mac_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : mac_share_sched
// Summary  : Round-robin scheduler time-sharing one multi-cycle multiplier
//            among NREQ requesters, each owning a private 2W-bit accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module mac_share_sched #(
  parameter int W       = 256,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       clr,
  input  logic [NREQ*W-1:0]     a_in,
  input  logic [NREQ*W-1:0]     b_in,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic [NREQ-1:0]       ovf,
  output logic [NREQ*2*W-1:0]   acc_out,
  output logic                  mul_start,
  output logic [W-1:0]          mul_a,
  output logic [W-1:0]          mul_b,
  input  logic                  mul_done,
  input  logic [2*W-1:0]        mul_p
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW = 2 * W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACCUM = 2'd3;

  localparam logic [7:0]    c_timeout  = 8'(TIMEOUT);
  localparam logic [IW-1:0] c_ptr_init = IW'(NREQ - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_sel;
  logic [IW-1:0] w_pick;
  logic [IW:0]   w_idx;
  logic          w_found;
  logic          w_grant;
  logic          w_accum;
  logic          w_timeout;
  logic          r_clr;
  logic [AW-1:0] r_prod;
  logic [7:0]    r_cnt;
  logic [AW-1:0] w_base;
  logic [AW:0]   w_sum;

  logic [W-1:0]  w_a   [NREQ];
  logic [W-1:0]  w_b   [NREQ];
  logic [AW-1:0] w_acc [NREQ];

  // First pending requester strictly after the last one served, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_idx >= (IW+1)'(NREQ)) begin
        w_idx = w_idx - (IW+1)'(NREQ);
      end
      if (!w_found && req[w_idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[IW-1:0];
      end
    end
  end

  assign w_timeout = (r_state == S_WAIT) && !mul_done && (r_cnt == c_timeout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (mul_done) begin
          w_state_nxt = S_ACCUM;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACCUM: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt       = '0;
    mul_start = 1'b0;
    w_grant   = 1'b0;
    w_accum   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant     = 1'b1;
          gnt[w_pick] = 1'b1;
        end
      end
      S_ISSUE: mul_start = 1'b1;
      S_ACCUM: w_accum   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= c_ptr_init;
      r_sel  <= '0;
      r_clr  <= 1'b0;
      mul_a  <= '0;
      mul_b  <= '0;
      r_prod <= '0;
      r_cnt  <= '0;
      done   <= '0;
      err    <= 1'b0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      if (w_grant) begin
        r_sel <= w_pick;
        r_clr <= clr[w_pick];
        mul_a <= w_a[w_pick];
        mul_b <= w_b[w_pick];
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= '0;
      end else if ((r_state == S_WAIT) && !mul_done && !w_timeout) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if ((r_state == S_WAIT) && mul_done) begin
        r_prod <= mul_p;
      end
      // Completion and abort both retire the op and move the priority pointer.
      if (w_accum || w_timeout) begin
        done  <= NREQ'(1) << r_sel;
        err   <= w_timeout;
        r_ptr <= r_sel;
      end
    end
  end

  assign w_base = r_clr ? '0 : w_acc[r_sel];
  assign w_sum  = {1'b0, w_base} + {1'b0, r_prod};

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_chan
      logic [AW-1:0] r_acc_ch;
      logic          r_ovf_ch;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_acc_ch <= '0;
          r_ovf_ch <= 1'b0;
        end else if (w_accum && (r_sel == IW'(i))) begin
          r_acc_ch <= w_sum[AW-1:0];
          r_ovf_ch <= (r_ovf_ch & ~r_clr) | w_sum[AW];
        end
      end

      assign w_a[i]                = a_in[i*W +: W];
      assign w_b[i]                = b_in[i*W +: W];
      assign w_acc[i]              = r_acc_ch;
      assign acc_out[i*AW +: AW]   = r_acc_ch;
      assign ovf[i]                = r_ovf_ch;
    end
  endgenerate

endmodule
`default_nettype wire
